// File: rtl/axi_wburst_master_pkg.sv
// Shared state encoding and AXI response codes for the burst write master.
package enuming;
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_CALC = 3'd1;
    localparam state_t ST_ADDR = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_RESP = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Severity order matches the numeric encoding, so the worst response is the max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/axi_wburst_master_calc.sv
// Combinational burst sizing: length limited by remaining beats, boundary room and MAX_LEN.
module axi_wburst_calc #(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_LEN    = 255,
    parameter int BOUNDARY   = 4096
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           remaining,
    input  logic [2:0]            size,
    output logic [8:0]            burst_beats,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic [15:0]           next_remaining
);
    logic [31:0] offset, room_beats, beats;

    always_comb begin
        offset     = 32'(addr) & 32'(BOUNDARY - 1);
        room_beats = (32'(BOUNDARY) - offset) >> size;
        beats      = 32'(remaining);
        if (room_beats < beats)
            beats = room_beats;
        if ((32'(MAX_LEN) + 32'd1) < beats)
            beats = 32'(MAX_LEN) + 32'd1;
        burst_beats    = beats[8:0];
        // Truncation to ADDR_WIDTH gives the modulo-2^ADDR_WIDTH wrap.
        next_addr      = addr + ADDR_WIDTH'(beats << size);
        next_remaining = remaining - beats[15:0];
    end
endmodule

// File: rtl/axi_wburst_master.sv
// AXI4 write master: splits a command into boundary/length-legal bursts, one outstanding at a time.
module axi_wburst_master
    import enuming::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_LEN    = 255,
    parameter int BOUNDARY   = 4096
) (
    input  logic                  clk,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_beats,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic                  done,
    output logic [1:0]            done_resp
);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           rem_q;
    logic [2:0]            size_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic [1:0]            agg_q;
    logic [1:0]            done_resp_q;

    logic [8:0]            calc_beats;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [15:0]           calc_rem;
    logic [31:0]           align_mask;
    logic                  cmd_bad;
    logic                  in_data_ph;
    logic                  w_fire;
    logic [1:0]            agg_next;

    axi_wburst_calc #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MAX_LEN   (MAX_LEN),
        .BOUNDARY  (BOUNDARY)
    ) u_calc (
        .addr          (addr_q),
        .remaining     (rem_q),
        .size          (size_q),
        .burst_beats   (calc_beats),
        .next_addr     (calc_addr),
        .next_remaining(calc_rem)
    );

    always_comb begin
        align_mask = (32'd1 << size_q) - 32'd1;
        cmd_bad    = (size_q > 3'(MAX_SIZE)) || ((32'(addr_q) & align_mask) != 32'd0);
        agg_next   = resp_max(agg_q, BRESP);
    end

    // cmd_ready is masked by reset so every output reads 0 while ARESET is held.
    assign cmd_ready  = (state == ST_IDLE) && !ARESET;
    assign AWVALID    = (state == ST_ADDR);
    assign AWADDR     = AWVALID ? addr_q : '0;
    assign AWLEN      = AWVALID ? len_q : '0;
    assign AWSIZE     = AWVALID ? size_q : '0;
    assign in_data_ph = (state == ST_DATA);
    assign WVALID     = in_data_ph && in_valid;
    assign in_ready   = in_data_ph && WREADY;
    assign WDATA      = in_data_ph ? in_data : '0;
    assign WLAST      = in_data_ph && (beat_cnt == len_q);
    assign w_fire     = WVALID && WREADY;
    assign BREADY     = (state == ST_RESP);
    assign done       = (state == ST_DONE);
    assign done_resp  = done_resp_q;

    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            size_q      <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            agg_q       <= RESP_OKAY;
            done_resp_q <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    addr_q <= cmd_addr;
                    rem_q  <= cmd_beats;
                    size_q <= cmd_size;
                    agg_q  <= RESP_OKAY;
                    state  <= ST_CALC;
                end
                ST_CALC: begin
                    if (rem_q == 16'd0) begin
                        done_resp_q <= agg_q;
                        state       <= ST_DONE;
                    end else if (cmd_bad) begin
                        done_resp_q <= resp_max(agg_q, RESP_SLVERR);
                        state       <= ST_DONE;
                    end else begin
                        len_q    <= 8'(calc_beats - 9'd1);
                        beat_cnt <= '0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: if (AWREADY) state <= ST_DATA;
                ST_DATA: if (w_fire) begin
                    if (WLAST) begin
                        beat_cnt <= '0;
                        state    <= ST_RESP;
                    end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                // addr_q/rem_q are untouched since CALC, so calc outputs still describe this burst.
                ST_RESP: if (BVALID) begin
                    agg_q  <= agg_next;
                    addr_q <= calc_addr;
                    rem_q  <= calc_rem;
                    if (calc_rem != 16'd0) begin
                        state <= ST_CALC;
                    end else begin
                        done_resp_q <= agg_next;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wburst_master.sv
// Scoreboard bench for axi_wburst_master: directed commands, AXI slave model, queued expectations.
module tb_axi_wburst_master;
    import enuming::*;

    logic        clk = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic [2:0]  cmd_size = '0;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        done;
    logic [1:0]  done_resp;

    always #5 clk = ~clk;

    axi_wburst_master dut (
        .clk(clk), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats), .cmd_size(cmd_size),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .done(done), .done_resp(done_resp)
    );

    typedef struct packed {logic [15:0] addr; logic [7:0] len; logic [2:0] size;} aw_t;
    typedef struct packed {logic [31:0] data; logic last;} w_t;

    aw_t        exp_aw[$];
    w_t         exp_w[$];
    logic [1:0] exp_done[$];
    logic [1:0] bq[$];
    int checks = 0, errors = 0;
    int exp_idx = 0, src_idx = 0, b_owed = 0;
    bit rnd_wready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic push_burst(input logic [15:0] a, input logic [7:0] len, input logic [2:0] s);
        aw_t e;
        w_t  w;
        e.addr = a; e.len = len; e.size = s;
        exp_aw.push_back(e);
        for (int i = 0; i <= int'(len); i++) begin
            w.data = 32'hA000_0000 + 32'(exp_idx);
            w.last = (i == int'(len));
            exp_w.push_back(w);
            exp_idx++;
        end
    endtask

    // Slave and data source: sample handshakes at negedge, update drives just after posedge.
    initial begin : slave
        logic w_f, wl_f, b_f;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; in_valid = 1; in_data = 32'hA000_0000;
        forever begin
            @(negedge clk);
            w_f  = WVALID && WREADY;
            wl_f = w_f && WLAST;
            b_f  = BVALID && BREADY;
            @(posedge clk);
            #1;
            if (w_f) src_idx++;
            in_valid = 1;
            in_data  = 32'hA000_0000 + 32'(src_idx);
            WREADY   = rnd_wready ? 1'($urandom_range(0, 1)) : 1'b1;
            AWREADY  = 1'($urandom_range(0, 1));
            if (b_f) BVALID = 0;
            if (wl_f) b_owed++;
            if (!BVALID && b_owed > 0) begin
                BVALID = 1;
                BRESP  = (bq.size() > 0) ? bq.pop_front() : RESP_OKAY;
                b_owed--;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!ARESET) begin
                if (AWVALID && AWREADY) begin
                    if (exp_aw.size() > 0) check("aw_burst", {AWADDR, AWLEN, AWSIZE}, exp_aw.pop_front());
                    else flag("aw_unexpected");
                end
                if (WVALID && WREADY) begin
                    if (exp_w.size() > 0) check("w_beat", {WDATA, WLAST}, exp_w.pop_front());
                    else flag("w_unexpected");
                end
                if (done) begin
                    if (exp_done.size() > 0) check("done_resp", 64'(done_resp), 64'(exp_done.pop_front()));
                    else flag("done_unexpected");
                end
            end
        end
    end

    task automatic run_cmd(input logic [15:0] a, input logic [15:0] n, input logic [2:0] s,
                           input logic [1:0] resp, input int budget, output int lat);
        int w = 0;
        exp_done.push_back(resp);
        @(posedge clk);
        #1;
        cmd_addr = a; cmd_beats = n; cmd_size = s; cmd_valid = 1;
        do begin @(negedge clk); w++; end while (!cmd_ready && w < 50);
        if (!cmd_ready) flag("cmd_accept_timeout");
        @(posedge clk);
        #1 cmd_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done && lat < budget);
        if (!done) flag("done_timeout");
        @(negedge clk);
        check("done_pulse_width", 64'(done), 64'd0);
        check("cmd_ready_after_done", 64'(cmd_ready), 64'd1);
        check("done_resp_hold", 64'(done_resp), 64'(resp));
        check("scoreboard_drained", 64'(exp_aw.size() + exp_w.size() + exp_done.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({AWVALID, WVALID, WLAST, BREADY, in_ready, done, done_resp, cmd_ready}), 64'd0);
        check({tag, "_bus"}, {5'd0, AWADDR, AWLEN, AWSIZE, WDATA}, 64'd0);
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int lat, k, base;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #3 ARESET = 0;
        @(negedge clk);
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Exact fit up to the 4KB boundary.
        bq.push_back(RESP_OKAY);
        push_burst(16'h0FE0, 8'd7, 3'd2);
        run_cmd(16'h0FE0, 16'd8, 3'd2, RESP_OKAY, 200, lat);

        // 4KB split: WLAST on beats 4 and 8.
        bq.push_back(RESP_OKAY); bq.push_back(RESP_OKAY);
        push_burst(16'h0FF0, 8'd3, 3'd2);
        push_burst(16'h1000, 8'd3, 3'd2);
        run_cmd(16'h0FF0, 16'd8, 3'd2, RESP_OKAY, 200, lat);

        // MAX_LEN split with random WREADY backpressure.
        rnd_wready = 1;
        bq.push_back(RESP_OKAY); bq.push_back(RESP_OKAY);
        push_burst(16'h0000, 8'd255, 3'd2);
        push_burst(16'h0400, 8'd43, 3'd2);
        run_cmd(16'h0000, 16'd300, 3'd2, RESP_OKAY, 5000, lat);
        rnd_wready = 0;

        // Error aggregation across the split.
        bq.push_back(RESP_OKAY); bq.push_back(RESP_SLVERR);
        push_burst(16'h0FF0, 8'd3, 3'd2);
        push_burst(16'h1000, 8'd3, 3'd2);
        run_cmd(16'h0FF0, 16'd8, 3'd2, RESP_SLVERR, 200, lat);

        run_cmd(16'h0FFB, 16'd8, 3'd2, RESP_SLVERR, 20, lat);
        check("misaligned_latency", 64'(lat), 64'd2);
        run_cmd(16'h0100, 16'd0, 3'd2, RESP_OKAY, 20, lat);
        check("empty_latency", 64'(lat), 64'd2);
        run_cmd(16'h0100, 16'd4, 3'd3, RESP_SLVERR, 20, lat);
        check("oversize_latency", 64'(lat), 64'd2);

        // Address wrap at the top of the space; DECERR dominates EXOKAY.
        bq.push_back(RESP_EXOKAY); bq.push_back(RESP_DECERR);
        push_burst(16'hFFF8, 8'd1, 3'd2);
        push_burst(16'h0000, 8'd1, 3'd2);
        run_cmd(16'hFFF8, 16'd4, 3'd2, RESP_DECERR, 200, lat);

        bq.push_back(RESP_EXOKAY);
        push_burst(16'h0040, 8'd2, 3'd1);
        run_cmd(16'h0040, 16'd3, 3'd1, RESP_EXOKAY, 200, lat);

        // Reset in the middle of a data phase abandons the command silently.
        rnd_wready = 1;
        push_burst(16'h0000, 8'd255, 3'd2);
        push_burst(16'h0400, 8'd43, 3'd2);
        base = src_idx;
        @(posedge clk);
        #1;
        cmd_addr = 16'h0000; cmd_beats = 16'd300; cmd_size = 3'd2; cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
        k = 0;
        while ((src_idx - base) < 20 && k < 3000) begin @(negedge clk); k++; end
        while (!WVALID && k < 3000) begin @(negedge clk); k++; end
        if (k >= 3000) flag("reach_data_timeout");
        rnd_wready = 0;
        @(posedge clk);
        #3 ARESET = 1;
        @(negedge clk);
        check_all_zero("mid_burst_reset");
        @(posedge clk);
        #3;
        exp_aw.delete(); exp_w.delete(); exp_done.delete(); bq.delete();
        src_idx = 0; exp_idx = 0; b_owed = 0; BVALID = 0;
        ARESET = 0;
        @(negedge clk);
        check("cmd_ready_after_midreset", 64'(cmd_ready), 64'd1);
        repeat (5) @(negedge clk);

        // Recovery after reset.
        bq.push_back(RESP_OKAY); bq.push_back(RESP_OKAY);
        push_burst(16'h0FF0, 8'd3, 3'd2);
        push_burst(16'h1000, 8'd3, 3'd2);
        run_cmd(16'h0FF0, 16'd8, 3'd2, RESP_OKAY, 200, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_wburst_master.md
AXI_WBURST_MASTER -- requirements
Module: axi_wburst_master

Interface
REQ-001 Parameter DATA_WIDTH, 32, W/in data width in bits; legal values are 32, 64 and 128.
REQ-002 Parameter ADDR_WIDTH, 16, AWADDR and cmd_addr width in bits.
REQ-003 Parameter MAX_LEN, 255, largest AWLEN the block issues; legal range is 0..255.
REQ-004 Parameter BOUNDARY, 4096, byte boundary that no burst may cross; must be a power of two.
REQ-005 clk  in  1  single clock; all logic samples on the rising edge.
REQ-006 ARESET  in  1  reset; asynchronous, active-high.
REQ-007 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_addr  in  ADDR_WIDTH  start byte address of the command.
REQ-009 cmd_beats  in  16  total number of beats; 0 means an empty command.
REQ-010 cmd_size  in  3  bytes per beat, encoded as 2^cmd_size.
REQ-011 in_data/in_valid/in_ready  in/in/out  DATA_WIDTH/1/1  write-data stream.
REQ-012 AWADDR/AWLEN/AWSIZE/AWVALID/AWREADY  out/out/out/out/in  ADDR_WIDTH/8/3/1/1  AXI4 write-address channel.
REQ-013 WDATA/WLAST/WVALID/WREADY  out/out/out/in  DATA_WIDTH/1/1/1  AXI4 write-data channel.
REQ-014 BRESP/BVALID/BREADY  in/in/out  2/1/1  AXI4 write-response channel.
REQ-015 done/done_resp  out/out  1/2  one-cycle completion pulse and the aggregated response.

Function
REQ-016 The FSM states are IDLE, CALC, ADDR, DATA, RESP and DONE.
REQ-017 IDLE: cmd_ready=1; a cmd handshake captures addr, beats and size, then goes to CALC.
REQ-018 CALC (1 cycle):
- If cmd_beats=0, go to DONE with OKAY.
- If cmd_size>log2(DATA_WIDTH/8), or cmd_addr is not aligned to 2^cmd_size, go to DONE with SLVERR.
- Either way, no AXI traffic is issued.
- Otherwise go to ADDR.
REQ-019 Burst length: burst_beats = min(remaining, (BOUNDARY - addr mod BOUNDARY) >> size, MAX_LEN+1); AWLEN = burst_beats-1.
REQ-020 ADDR: AWVALID=1 with stable AWADDR/AWLEN/AWSIZE until the AWREADY handshake, then go to DATA.
REQ-021 W is never driven before its AW handshake completes; only one burst is outstanding at a time.
REQ-022 DATA signals:
- WDATA=in_data.
- WVALID=in_valid.
- in_ready=WREADY.
- All three are zero outside DATA.
REQ-023 The beat counter advances on each W handshake; WLAST=1 exactly on beat burst_beats-1; after the WLAST handshake go to RESP.
REQ-024 RESP: BREADY=1 until the BVALID handshake.
REQ-025 Response aggregation: the aggregate is the numeric max of itself and BRESP (DECERR>SLVERR>EXOKAY>OKAY).
REQ-026 Next burst: addr += burst_beats<<size and remaining -= burst_beats; if remaining>0 go to CALC, else go to DONE.
REQ-027 DONE (1 cycle): done=1, done_resp=aggregate, then return to IDLE.
REQ-028 done_resp holds its value until the next done pulse.
REQ-029 An error BRESP does not abort the command; all remaining bursts are still issued.
REQ-030 Address arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-031 Back-to-back commands: cmd_ready reasserts the cycle after done.

Reset
REQ-032 While ARESET=1, the FSM goes to IDLE and the counters and aggregate clear.
REQ-033 While ARESET=1, every output is 0: AWVALID, WVALID, WLAST, BREADY, in_ready, done, done_resp, cmd_ready, AWADDR, AWLEN, AWSIZE, WDATA.
REQ-034 A reset mid-burst abandons the command immediately; no done pulse is produced for it.
REQ-035 cmd_ready rises in the first clk cycle after ARESET deasserts.

Structure
REQ-036 The FSM state typedef and the OKAY/EXOKAY/SLVERR/DECERR constants live in package enuming.
REQ-037 The burst-length and next-address arithmetic of REQ-019 and REQ-026 is one combinational sub-module, axi_wburst_calc.
REQ-038 All state elements reside in axi_wburst_master.

Verification
REQ-039 Exact fit: addr 0x0FE0, beats 8, size 2 -> one burst, AWADDR 0x0FE0, AWLEN 7; done_resp OKAY.
REQ-040 4KB split: addr 0x0FF0, beats 8, size 2 -> bursts (0x0FF0, AWLEN 3) then (0x1000, AWLEN 3); WLAST on beats 4 and 8.
REQ-041 Length split: addr 0x0000, beats 300, size 2, MAX_LEN 255 -> bursts (0x0000, AWLEN 255) then (0x0400, AWLEN 43).
REQ-042 Error aggregation: the split case of REQ-040 with BRESP OKAY then SLVERR -> done_resp SLVERR, both bursts completed.
REQ-043 Illegal command: addr 0x0FFB, size 2 -> no AWVALID, done with SLVERR two cycles after accept.
REQ-044 Backpressure/reset: WREADY toggled randomly during REQ-041 gives 300 ordered beats; ARESET pulsed mid-DATA -> all outputs 0, cmd_ready=1 next cycle.
